alarm_controller: RTL

// - Anti-theft alarm sequencer. Owns the one countdown timer instance: pulses start_timer with a selected

---
 rtl/alarm_controller_if.sv | 15 +
 rtl/alarm_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alarm_controller_if.sv
// alarm_controller_if
//   Handshake between the alarm sequencer and its countdown timer.
//   start_timer : one-cycle start pulse (sequencer -> timer)
//   value       : delay to load, valid while start_timer=1 (sequencer -> timer)
//   expired     : one-cycle expiry pulse (timer -> sequencer)
//   modport master : sequencer side
//   modport slave  : timer side
interface alarm_controller_if;
    logic       start_timer;
    logic [3:0] value;
    logic       expired;

    modport master (output start_timer, output value, input expired);
    modport slave  (input start_timer, input value, output expired);
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller
//   Anti-theft alarm sequencer. Drives one external countdown timer through
//   alarm_controller_if, holds a 4-entry programmable delay table and produces
//   registered (Moore) siren / status LED outputs.
// Ports
//   clk_104mhz      system clock
//   reset           synchronous, active-high
//   ignition        ignition switch level
//   driver_door     1 = driver door open
//   passenger_door  1 = passenger door open
//   reprogram       pulse: table[time_param_sel] <= time_value
//   time_param_sel  table index (0 arm, 1 driver, 2 passenger, 3 alarm)
//   time_value      value to write
//   brake           brake pedal (FUEL_PUMP_EN builds only)
//   hidden_sw       hidden switch (FUEL_PUMP_EN builds only)
//   tmr             timer handshake (master side)
//   siren           sounder enable
//   status_led      armed / alarm indicator
//   fuel_pump       fuel pump power
// Build option
//   FUEL_PUMP_EN : adds brake / hidden_sw and the fuel pump interlock;
//                  without it fuel_pump is tied low.
module alarm_controller #(
    parameter logic [3:0] T_ARM_DEF    = 4'd6,
    parameter logic [3:0] T_DRIVER_DEF = 4'd8,
    parameter logic [3:0] T_PASS_DEF   = 4'd15,
    parameter logic [3:0] T_ALARM_DEF  = 4'd10
) (
    input  logic                clk_104mhz,
    input  logic                reset,
    input  logic                ignition,
    input  logic                driver_door,
    input  logic                passenger_door,
    input  logic                reprogram,
    input  logic [1:0]          time_param_sel,
    input  logic [3:0]          time_value,
`ifdef FUEL_PUMP_EN
    input  logic                brake,
    input  logic                hidden_sw,
`endif
    alarm_controller_if.master  tmr,
    output logic                siren,
    output logic                status_led,
    output logic                fuel_pump
);

    localparam logic [2:0] S_ARMED      = 3'd0;
    localparam logic [2:0] S_TRIGGERED  = 3'd1;
    localparam logic [2:0] S_SOUND      = 3'd2;
    localparam logic [2:0] S_HOLD       = 3'd3;
    localparam logic [2:0] S_DISARMED   = 3'd4;
    localparam logic [2:0] S_WAIT_OPEN  = 3'd5;
    localparam logic [2:0] S_WAIT_CLOSE = 3'd6;
    localparam logic [2:0] S_ARM_DLY    = 3'd7;

    logic [2:0] state_q, state_d;
    logic [3:0] tbl_q [4];
    logic       start_q, start_d;
    logic [3:0] value_q, value_d;
    logic       siren_q, siren_d;
    logic       led_q, led_d;
    logic       exp_ok;

    // An expiry arriving while our own start pulse is still on the bus
    // belongs to the previous run and is dropped.
    assign exp_ok = tmr.expired & ~start_q;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        value_d = 4'd0;
        if (reprogram) begin
            state_d = S_ARMED;
        end else if (ignition && state_q != S_DISARMED) begin
            state_d = S_DISARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    // driver door has priority when both open together
                    if (driver_door) begin
                        state_d = S_TRIGGERED;
                        start_d = 1'b1;
                        value_d = tbl_q[1];
                    end else if (passenger_door) begin
                        state_d = S_TRIGGERED;
                        start_d = 1'b1;
                        value_d = tbl_q[2];
                    end
                end
                S_TRIGGERED: if (exp_ok) state_d = S_SOUND;
                S_SOUND: begin
                    if (!driver_door && !passenger_door) begin
                        state_d = S_HOLD;
                        start_d = 1'b1;
                        value_d = tbl_q[3];
                    end
                end
                S_HOLD: begin
                    if (driver_door || passenger_door) state_d = S_SOUND;
                    else if (exp_ok)                   state_d = S_ARMED;
                end
                S_DISARMED:  if (!ignition)   state_d = S_WAIT_OPEN;
                S_WAIT_OPEN: if (driver_door) state_d = S_WAIT_CLOSE;
                S_WAIT_CLOSE: begin
                    if (!driver_door) begin
                        state_d = S_ARM_DLY;
                        start_d = 1'b1;
                        value_d = tbl_q[0];
                    end
                end
                S_ARM_DLY: begin
                    if (driver_door)  state_d = S_WAIT_CLOSE;
                    else if (exp_ok)  state_d = S_ARMED;
                end
                default: state_d = S_ARMED;
            endcase
        end
        // Moore outputs computed from the next state so they register
        // alongside it.
        siren_d = (state_d == S_SOUND) || (state_d == S_HOLD);
        led_d   = ~state_d[2];
    end

    always_ff @(posedge clk_104mhz) begin
        if (reset) begin
            state_q  <= S_ARMED;
            start_q  <= 1'b0;
            value_q  <= 4'd0;
            siren_q  <= 1'b0;
            led_q    <= 1'b1;
            tbl_q[0] <= T_ARM_DEF;
            tbl_q[1] <= T_DRIVER_DEF;
            tbl_q[2] <= T_PASS_DEF;
            tbl_q[3] <= T_ALARM_DEF;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            value_q <= value_d;
            siren_q <= siren_d;
            led_q   <= led_d;
            if (reprogram) tbl_q[time_param_sel] <= time_value;
        end
    end

    assign tmr.start_timer = start_q;
    assign tmr.value       = value_q;
    assign siren           = siren_q;
    assign status_led      = led_q;

`ifdef FUEL_PUMP_EN
    logic fuel_q, fuel_d;

    always_comb begin
        fuel_d = fuel_q;
        if (reprogram)                         fuel_d = 1'b0;
        else if (ignition && brake && hidden_sw) fuel_d = 1'b1;
        else if (!ignition)                    fuel_d = 1'b0;
    end

    always_ff @(posedge clk_104mhz) begin
        if (reset) fuel_q <= 1'b0;
        else       fuel_q <= fuel_d;
    end

    assign fuel_pump = fuel_q;
`else
    assign fuel_pump = 1'b0;
`endif

endmodule
